// File: rtl/wb_region_decoder.sv
// Wishbone B4 classic 1-to-N address decoder with registered response, error on unmapped
// addresses and master-abort handling. Define WB_DEC_TIMEOUT_EN to add the per-access watchdog.
module wb_region_decoder #(
  parameter int                       NUM_SLAVES         = 4,
  // Slave 0 occupies the least significant lane of both packed vectors.
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASES        = {32'hF8000000, 32'h80000000,
                                                            32'hF0000800, 32'hF0000000},
  parameter logic [NUM_SLAVES*8-1:0]  SLAVE_AW           = {8'd14, 8'd27, 8'd11, 8'd11},
  parameter logic [31:0]              DEFAULT_READ_VALUE = 32'hBADFABAC,
  parameter int                       TIMEOUT_CYCLES     = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                m_adr_i,
  input  logic [31:0]                m_dat_i,
  input  logic [3:0]                 m_sel_i,
  input  logic                       m_we_i,
  input  logic                       m_stb_i,
  input  logic                       m_cyc_i,
  output logic [31:0]                m_dat_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [NUM_SLAVES*32-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_err_i
`ifdef WB_DEC_TIMEOUT_EN
  ,
  output logic                       timeout_seen_o
`endif
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("wb_region_decoder: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             adr_q, adr_d;
  logic [31:0]             wdat_q, wdat_d;
  logic [3:0]              sel_q, sel_d;
  logic                    we_q, we_d;
  logic [NUM_SLAVES-1:0]   stb_q, stb_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdat_q, rdat_d;
  logic [NUM_SLAVES-1:0]   hit;
  logic [31:0]             sel_dat;
  logic                    sel_ack;
  logic                    sel_err;
  logic                    req;

`ifdef WB_DEC_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  // Bits below the slave's AW are offset bits and take no part in the decode.
  function automatic logic region_hit(input logic [31:0] adr, input int idx);
    logic [31:0] base;
    logic [31:0] mask;
    base = SLAVE_BASES[32*idx +: 32];
    mask = 32'hFFFF_FFFF << SLAVE_AW[8*idx +: 8];
    return ((adr ^ base) & mask) == 32'h0;
  endfunction

  // Scanning downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (region_hit(m_adr_i, i)) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  // stb_q is one-hot in FWD, so it doubles as the select for the response mux.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (stb_q[i]) sel_dat = sel_dat | s_dat_i[32*i +: 32];
    end
  end

  assign sel_ack = |(s_ack_i & stb_q);
  assign sel_err = |(s_err_i & stb_q);
  assign req     = m_cyc_i & m_stb_i;

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
`ifdef WB_DEC_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d  = m_adr_i;
          wdat_d = m_dat_i;
          sel_d  = m_sel_i;
          we_d   = m_we_i;
          if (|hit) begin
            stb_d   = hit;
            state_d = FWD;
`ifdef WB_DEC_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            rdat_d  = DEFAULT_READ_VALUE;
            state_d = RESP;
          end
        end
      end
      FWD: begin
        if (!req) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_err) begin
          stb_d   = '0;
          err_d   = 1'b1;
          rdat_d  = DEFAULT_READ_VALUE;
          state_d = RESP;
        end else if (sel_ack) begin
          stb_d   = '0;
          ack_d   = 1'b1;
          if (!we_q) rdat_d = sel_dat;
          state_d = RESP;
        end
`ifdef WB_DEC_TIMEOUT_EN
        // The FWD cycle whose increment would reach the limit is the last one waited.
        else if (cnt_q == TMO_LAST) begin
          stb_d   = '0;
          err_d   = 1'b1;
          rdat_d  = DEFAULT_READ_VALUE;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef WB_DEC_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
`ifdef WB_DEC_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign m_dat_o = rdat_q;
  assign m_ack_o = ack_q;
  assign m_err_o = err_q;
  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_sel_o = sel_q;
  assign s_we_o  = we_q;
  assign s_cyc_o = stb_q;
  assign s_stb_o = stb_q;
`ifdef WB_DEC_TIMEOUT_EN
  assign timeout_seen_o = tmo_q;
`endif

endmodule
